keypad_scanner: RTL and testbench

//  Scan side of the 4x4 matrix keypad: drives one column low at a time, samples the

---
 rtl/keypad_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, key encode, valid/ack handoff.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int clk_freq    = 125_000_000,
    parameter int stable_time = 1000,
    parameter int scan_div    = 1000,
    parameter int repeat_time = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_ovf,
    output logic       busy
);

    localparam longint CPU        = longint'(clk_freq / 1_000_000);
    localparam longint STABLE_CNT = CPU * longint'(stable_time);
    localparam int     SW = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
    localparam int     DW = (scan_div > 2) ? $clog2(scan_div) : 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [DW-1:0] SCAN_LAST   = DW'(scan_div - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    rs1_q, rs_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] scan_cnt_q, scan_cnt_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [3:0]    key_code_q;
    logic          key_valid_q, key_ovf_q;
    logic          press, idle, commit, rep_fire;
    logic [1:0]    ridx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= 4'hF;
            rs_q  <= 4'hF;
        end else begin
            rs1_q <= row;
            rs_q  <= rs1_q;
        end
    end

    // Multi-row patterns are neither a press nor a release.
    always_comb begin
        press = 1'b1;
        ridx  = 2'd0;
        unique case (rs_q)
            4'b1110: ridx = 2'd0;
            4'b1101: ridx = 2'd1;
            4'b1011: ridx = 2'd2;
            4'b0111: ridx = 2'd3;
            default: press = 1'b0;
        endcase
    end

    assign idle = (rs_q == 4'b1111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
            cnt_q      <= '0;
            pat_q      <= 4'hF;
            ridx_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            scan_cnt_q <= scan_cnt_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            ridx_q     <= ridx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        scan_cnt_d = scan_cnt_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        ridx_d     = ridx_q;
        unique case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (press) begin
                        state_d = DEBOUNCE;
                        pat_d   = rs_q;
                        ridx_d  = ridx;
                        cnt_d   = '0;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (rs_q != pat_q) begin
                    state_d    = SCAN;
                    col_idx_d  = col_idx_q + 2'd1;
                    scan_cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            HELD: begin
                if (idle) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (idle) begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d    = SCAN;
                        col_idx_d  = col_idx_q + 2'd1;
                        scan_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end else if (press) begin
                    state_d = HELD;
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam longint REPEAT_CNT = CPU * longint'(repeat_time);
    localparam int     RW = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CNT - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          stay_held;

    assign stay_held = (state_q == HELD) && (state_d == HELD);
    assign rep_fire  = stay_held && (rep_cnt_q == REPEAT_LAST);

    always_comb begin
        rep_cnt_d = '0;
        if (stay_held && !rep_fire)
            rep_cnt_d = rep_cnt_q + RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        col    = ~(4'b0001 << col_idx_q);
        busy   = (state_q != SCAN);
        commit = ((state_q == DEBOUNCE) && (rs_q == pat_q)
                  && (cnt_q == STABLE_LAST)) || rep_fire;
    end

    // A commit coinciding with an ack replaces the key instead of overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_ovf_q   <= 1'b0;
        end else begin
            key_ovf_q <= 1'b0;
            if (commit) begin
                if (!key_valid_q || key_ack) begin
                    key_code_q  <= {ridx_q, col_idx_q};
                    key_valid_q <= 1'b1;
                end else begin
                    key_ovf_q <= 1'b1;
                end
            end else if (key_ack) begin
                key_valid_q <= 1'b0;
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_ovf   = key_ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-driven keypad model.
module tb_keypad_scanner;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_ovf;
    logic       busy;

    logic       press_en;
    logic [1:0] pr, pc;

    int checks = 0;
    int fails  = 0;
    int rises = 0, ovf_cycles = 0, ovf_rises = 0;
    logic kv_prev = 1'b0, ovf_prev = 1'b0;

    keypad_scanner #(
        .clk_freq   (125_000_000),
        .stable_time(1),
        .scan_div   (8),
        .repeat_time(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_ovf  (key_ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        if (press_en && col[pc] == 1'b0)
            row[pr] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid && !kv_prev) rises++;
        kv_prev = key_valid;
        if (key_ovf) ovf_cycles++;
        if (key_ovf && !ovf_prev) ovf_rises++;
        ovf_prev = key_ovf;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, base_ovf, n, nk;
        logic [3:0] last_code;

        rst_n = 1'b0;
        press_en = 1'b0;
        key_ack = 1'b0;
        pr = 2'd0;
        pc = 2'd0;

        // 1: reset values, scan stepping, mid-scan reset
        step(3);
        chk("rst_col", col, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", key_ovf, 1'b0);
        rst_n = 1'b1;
        step(13);
        chk("scan_col", col, 4'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", key_valid, 1'b0);
        step(1);
        rst_n = 1'b1;

        // 2: single press (2,1), then ack
        pr = 2'd2;
        pc = 2'd1;
        press_en = 1'b1;
        step(400);
        chk("p21_valid", key_valid, 1'b1);
        chk("p21_code", key_code, 4'h9);
        chk("p21_col", col, 4'b1101);
        chk("p21_busy", busy, 1'b1);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        chk("p21_ack", key_valid, 1'b0);
        press_en = 1'b0;
        step(300);
        chk("p21_idle", busy, 1'b0);

        // 3: bouncing (0,3), then stable
        base = rises;
        pr = 2'd0;
        pc = 2'd3;
        for (int i = 0; i < 20; i++) begin
            press_en = (i % 2 == 0);
            step(40);
        end
        chk("bounce_none", rises - base, 0);
        press_en = 1'b1;
        step(400);
        chk("bounce_one", rises - base, 1);
        chk("bounce_code", key_code, 4'h3);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        press_en = 1'b0;
        step(300);

        // 4: long hold (3,0), release timing
        base = rises;
        pr = 2'd3;
        pc = 2'd0;
        press_en = 1'b1;
        step(2000);
        chk("hold_one", rises - base, 1);
        chk("hold_code", key_code, 4'hC);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        press_en = 1'b0;
        step(100);
        n = 100;
        chk("rel_early", busy, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            step(1);
            n++;
        end
        chk("rel_done", busy, 1'b0);
        chk("rel_latency", (n >= 125), 1'b1);
        chk("rel_col", col, 4'b1101);

        // 5: overflow, then commit coinciding with ack
        base_ovf = ovf_cycles;
        pr = 2'd1;
        pc = 2'd2;
        press_en = 1'b1;
        step(300);
        chk("ovf_first", key_code, 4'h6);
        press_en = 1'b0;
        step(300);
        pr = 2'd0;
        pc = 2'd0;
        press_en = 1'b1;
        step(300);
        chk("ovf_cycles", ovf_cycles - base_ovf, 1);
        chk("ovf_rises", ovf_rises, 1);
        chk("ovf_code", key_code, 4'h6);
        chk("ovf_valid", key_valid, 1'b1);
        press_en = 1'b0;
        step(300);
        base_ovf = ovf_cycles;
        press_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (busy) break;
        end
        chk("sim_detect", busy, 1'b1);
        repeat (124) @(posedge clk);
        #1;
        chk("sim_pre_code", key_code, 4'h6);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        chk("sim_valid", key_valid, 1'b1);
        chk("sim_code", key_code, 4'h0);
        step(5);
        chk("sim_no_ovf", ovf_cycles - base_ovf, 0);
        key_ack = 1'b1;
        step(1);
        key_ack = 1'b0;
        press_en = 1'b0;
        step(300);

        // 6: held (2,2) with acks; repeat only when the feature is built in
        pr = 2'd2;
        pc = 2'd2;
        press_en = 1'b1;
        nk = 0;
        last_code = 4'h0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            key_ack = 1'b0;
            if (key_valid) begin
                nk++;
                last_code = key_code;
                key_ack = 1'b1;
            end
        end
        key_ack = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        chk("rep_count", nk, 3);
`else
        chk("rep_count", nk, 1);
`endif
        chk("rep_code", last_code, 4'hA);
        press_en = 1'b0;
        step(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
